// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// controller state encoding and operand-forwarding source codes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_e;

  // Operand source selects driven onto fwd_a / fwd_b.
  localparam logic [1:0] FWD_RF   = 2'b00;  // register file
  localparam logic [1:0] FWD_EXE  = 2'b01;  // EXE-stage ALU result
  localparam logic [1:0] FWD_MALU = 2'b10;  // MEM-stage ALU result
  localparam logic [1:0] FWD_MMO  = 2'b11;  // MEM-stage load data

  localparam int unsigned WCNT_W = 5;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one source operand. The youngest producer wins:
// a non-load EXE-stage writer beats any MEM-stage writer. Register 0 is
// hard-wired zero and never forwarded.
module fwd_unit (
  input  logic [4:0] src,
  input  logic       exe_wreg,
  input  logic       exe_m2reg,
  input  logic [4:0] exe_rn,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_rn,
  output logic [1:0] fwd
);
  import pipe_ctrl_pkg::*;

  // Priority select of the operand source.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (that would infer a latch).
    fwd = FWD_RF;
    if (src != 5'd0) begin
      if (exe_wreg && !exe_m2reg && (exe_rn == src)) begin
        fwd = FWD_EXE;
      end else if (mem_wreg && (mem_rn == src)) begin
        fwd = mem_m2reg ? FWD_MMO : FWD_MALU;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall FSM with timeout error,
// load-use bubble insertion, branch flush and operand forwarding selects.
// Optional build macro HAZ_PERF_CNT_EN adds a 32-bit stall_cnt output that
// counts cycles with stall_fe asserted.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        br_taken,
  input  logic        exe_wreg,
  input  logic        exe_m2reg,
  input  logic [4:0]  exe_rn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [4:0]  mem_rn,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_fe,
  output logic        bubble_ex,
  output logic        ifid_flush,
  output logic        hold_mem,
  output logic        wb_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  import pipe_ctrl_pkg::*;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_stall;
  logic              load_use;
  logic              stall_any;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  // A load in EXE whose destination the ID instruction reads needs one bubble.
  assign load_use = exe_wreg && exe_m2reg && (exe_rn != 5'd0) &&
                    ((id_use_rs && (exe_rn == id_rs)) ||
                     (id_use_rt && (exe_rn == id_rt)));

  // State and wait-counter registers; reset returns to RUN at once.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state and memory stall; a stall is raised in the request cycle
  // itself and dropped combinationally in the cycle mem_ready arrives.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    case (state_q)
      RUN: begin
        mem_stall = mem_req && !mem_ready;
        if (mem_req && !mem_ready) begin
          state_d = MWAIT;
          wcnt_d  = '0;
        end
      end
      MWAIT: begin
        mem_stall = !mem_ready;
        if (mem_ready) begin
          state_d = RUN;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Pipeline control outputs: memory wait > load-use > branch flush.
  // Everything is forced quiet while reset is held.
  always_comb begin
    stall_any  = 1'b0;
    stall_fe   = 1'b0;
    bubble_ex  = 1'b0;
    ifid_flush = 1'b0;
    hold_mem   = 1'b0;
    wb_bubble  = 1'b0;
    if (clrn) begin
      stall_any  = mem_stall || load_use;
      stall_fe   = stall_any;
      hold_mem   = mem_stall;
      wb_bubble  = mem_stall;
      bubble_ex  = load_use && !mem_stall;
      ifid_flush = br_taken && !stall_any;
    end
  end

  assign err = (state_q == ERR);

  fwd_unit u_fwd_rs (
    .src       (id_rs),
    .exe_wreg  (exe_wreg),
    .exe_m2reg (exe_m2reg),
    .exe_rn    (exe_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .fwd       (fwd_a_raw)
  );

  fwd_unit u_fwd_rt (
    .src       (id_rt),
    .exe_wreg  (exe_wreg),
    .exe_m2reg (exe_m2reg),
    .exe_rn    (exe_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .fwd       (fwd_b_raw)
  );

  assign fwd_a = clrn ? fwd_a_raw : FWD_RF;
  assign fwd_b = clrn ? fwd_b_raw : FWD_RF;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running count of front-end stall cycles, wrapping naturally.
  always_comb begin
    stall_cnt_d = stall_fe ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
